// File: rtl/rc4_pkg.sv
// ============================================================================
// Module      : rc4_pkg
// Description : Shared byte width and receive-buffer FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_pkg;

    localparam int RC4_BYTE_W = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FILL     = 2'd1;
    localparam logic [1:0] ST_WAIT_KEY = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rc4_rx_mem.sv
// ============================================================================
// Module      : rc4_rx_mem
// Description : DEPTH x DW simple dual-port RAM, synchronous write and read.
//               Only the read register is reset; array contents persist.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_rx_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read register only updates on rd_en so the presented byte holds during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/rc4_rx_frame_buffer.sv
// ============================================================================
// Module      : rc4_rx_frame_buffer
// Description : Store-and-forward single-frame receive buffer; replays a stored
//               ciphertext frame to the decrypt core once keystream is ready.
//               Optional macro RC4_RX_DROP_CNT_EN adds the drop_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_rx_frame_buffer
    import rc4_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = RC4_BYTE_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          key_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
`ifdef RC4_RX_DROP_CNT_EN
    output logic [15:0]   drop_cnt,
`endif
    output logic          overflow
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_len_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_len;
    logic [AW:0]   r_rd_ptr;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_overflow;

    logic w_accept;
    logic w_room;
    logic w_wr_en;
    logic w_take;
    logic w_fetch;

    assign in_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_FILL));
    assign w_accept = in_valid && in_ready;
    assign w_room   = (r_len < c_depth);
    assign w_wr_en  = w_accept && w_room;
    assign w_take   = r_out_valid && out_ready;
    // A fetch refills the output slot when it is empty or being emptied this cycle.
    assign w_fetch  = (r_state == ST_DRAIN) && key_ready && (r_rd_ptr < r_len) &&
                      (!r_out_valid || out_ready);

    rc4_rx_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr),
        .wr_data (in_data),
        .rd_en   (w_fetch),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .rd_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_len       <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_len    <= r_len + c_len_one;
            end
            if (w_accept && !w_room) begin
                r_overflow <= 1'b1;
            end

            if (w_fetch) begin
                r_out_valid <= 1'b1;
                r_out_last  <= (r_rd_ptr == (r_len - c_len_one));
                r_rd_ptr    <= r_rd_ptr + c_len_one;
            end else if (w_take) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= in_last ? ST_WAIT_KEY : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_accept && in_last) begin
                        r_state <= ST_WAIT_KEY;
                    end
                end
                ST_WAIT_KEY: begin
                    if (key_ready) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_take && r_out_last) begin
                        r_state  <= ST_IDLE;
                        r_wr_ptr <= '0;
                        r_len    <= '0;
                        r_rd_ptr <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;

`ifdef RC4_RX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_room && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire
